// File: rtl/cpu_clk_en_pkg.sv
// Shared definitions for the CPU clock-enable generator: FSM encoding and
// default divider taps.
package cpu_clk_en_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  localparam int DEF_FAST_TAP = 1;
  localparam int DEF_SLOW_TAP = 24;

endpackage

// File: rtl/cpu_clk_en_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a registered
// rising-edge pulse derived from the synchronized level.
module sync_edge
  import cpu_clk_en_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // next-state: shift through the synchronizer and detect a 0->1 step
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  // synchronizer and edge registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cpu_clk_en.sv
// CPU clock-enable generator: turns a divider tap (fast/slow) or a
// single-step button into a one-cycle cpu_en strobe on the system clock.
module cpu_clk_en
  import cpu_clk_en_pkg::*;
#(
  parameter int DIV_W    = 32,
  parameter int FAST_TAP = DEF_FAST_TAP,
  parameter int SLOW_TAP = DEF_SLOW_TAP,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             sw_slow,
  input  logic             step_mode,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             tap_sel,
  output logic             switching,
  output logic [CNT_W-1:0] en_count
);

  function automatic logic tap_bit(input logic [DIV_W-1:0] div, input logic sel);
    return sel ? div[SLOW_TAP] : div[FAST_TAP];
  endfunction

  logic sw_sync, mode_sync, step_edge;
  logic sw_rise_unused, mode_rise_unused, btn_level_unused;
  logic unused_div;

  sync_edge u_sw_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sw_slow),
    .level (sw_sync),
    .rise  (sw_rise_unused)
  );

  sync_edge u_mode_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (step_mode),
    .level (mode_sync),
    .rise  (mode_rise_unused)
  );

  sync_edge u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (step_btn),
    .level (btn_level_unused),
    .rise  (step_edge)
  );

  // Only the two tap bits of the divider are consumed.
  assign unused_div = ^clkdiv;

  state_e           state_q, state_d;
  logic             tap_sel_q, tap_sel_d;
  logic             tap_prev_q, tap_prev_d;
  logic             cpu_en_q, cpu_en_d;
  logic             switching_q, switching_d;
  logic [CNT_W-1:0] en_count_q, en_count_d;
  logic             cur_bit, new_bit, tick;

  // next-state, strobe and counter logic; a mode/tap change always drops a coincident event
  always_comb begin
    cur_bit    = tap_bit(clkdiv, tap_sel_q);
    new_bit    = tap_bit(clkdiv, sw_sync);
    tick       = cur_bit & ~tap_prev_q;
    state_d    = state_q;
    tap_sel_d  = tap_sel_q;
    tap_prev_d = cur_bit;
    cpu_en_d   = 1'b0;
    if (mode_sync && (state_q != ST_STEP)) begin
      state_d = ST_STEP;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sw_sync != tap_sel_q) begin
            state_d    = ST_SWITCH;
            tap_sel_d  = sw_sync;
            tap_prev_d = new_bit;
          end else begin
            cpu_en_d = tick & ~halt;
          end
        end
        ST_SWITCH: begin
          if (sw_sync != tap_sel_q) begin
            tap_sel_d  = sw_sync;
            tap_prev_d = new_bit;
          end else if (tick) begin
            cpu_en_d = ~halt;
            state_d  = ST_RUN;
          end else begin
            state_d = ST_SWITCH;
          end
        end
        ST_STEP: begin
          if (!mode_sync) begin
            state_d    = ST_SWITCH;
            tap_sel_d  = sw_sync;
            tap_prev_d = new_bit;
          end else begin
            cpu_en_d = step_edge & ~halt;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    switching_d = (state_d == ST_SWITCH);
    en_count_d  = en_count_q + {{(CNT_W-1){1'b0}}, cpu_en_d};
  end

  // FSM and registered outputs; tap_prev resets high so a tap already high is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tap_sel_q   <= 1'b0;
      tap_prev_q  <= 1'b1;
      cpu_en_q    <= 1'b0;
      switching_q <= 1'b0;
      en_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      tap_sel_q   <= tap_sel_d;
      tap_prev_q  <= tap_prev_d;
      cpu_en_q    <= cpu_en_d;
      switching_q <= switching_d;
      en_count_q  <= en_count_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign tap_sel   = tap_sel_q;
  assign switching = switching_q;
  assign en_count  = en_count_q;

endmodule

// File: tb/tb_cpu_clk_en.sv
// Self-checking bench for cpu_clk_en: scenario tasks plus a behavioural
// model built from divider-bit rising edges and delay lines.
module tb_cpu_clk_en;

  localparam int DIV_W = 32;
  localparam int FAST  = 1;
  localparam int SLOW  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] clkdiv = 32'd0;
  logic             sw_slow = 1'b0;
  logic             step_mode = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt = 1'b0;
  logic             cpu_en, tap_sel, switching;
  logic [CNT_W-1:0] en_count;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  // model state: input delay lines, operating mode flags, previous divider value
  logic [1:0]       m_sw_line, m_st_line;
  logic [2:0]       m_btn_line;
  logic             m_edge, m_tap, m_pending, m_stepping, m_prev_ok;
  logic [DIV_W-1:0] m_prev_div;
  logic             exp_en, exp_tap, exp_sw;
  logic [CNT_W-1:0] exp_cnt;

  cpu_clk_en #(
    .DIV_W    (DIV_W),
    .FAST_TAP (FAST),
    .SLOW_TAP (SLOW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkdiv    (clkdiv),
    .sw_slow   (sw_slow),
    .step_mode (step_mode),
    .step_btn  (step_btn),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .tap_sel   (tap_sel),
    .switching (switching),
    .en_count  (en_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sw_line = 2'b00; m_st_line = 2'b00; m_btn_line = 3'b000; m_edge = 1'b0;
    m_tap = 1'b0; m_pending = 1'b0; m_stepping = 1'b0; m_prev_ok = 1'b0;
    m_prev_div = 32'd0;
    exp_en = 1'b0; exp_tap = 1'b0; exp_sw = 1'b0; exp_cnt = 4'd0;
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    logic sw_s, st_s, rise, en;
    int   cur;
    if (rst) begin
      model_reset();
      return;
    end
    sw_s = m_sw_line[1];
    st_s = m_st_line[1];
    cur  = m_tap ? SLOW : FAST;
    rise = clkdiv[cur] && !(m_prev_ok ? m_prev_div[cur] : 1'b1);
    en   = 1'b0;
    if (m_stepping) begin
      if (!st_s) begin
        m_stepping = 1'b0; m_pending = 1'b1; m_tap = sw_s;
      end else begin
        en = m_edge && !halt;
      end
    end else if (st_s) begin
      m_stepping = 1'b1; m_pending = 1'b0;
    end else if (sw_s != m_tap) begin
      m_tap = sw_s; m_pending = 1'b1;
    end else if (m_pending) begin
      if (rise) begin
        en = !halt; m_pending = 1'b0;
      end
    end else begin
      en = rise && !halt;
    end
    exp_en  = en;
    exp_cnt = exp_cnt + CNT_W'(en);
    exp_tap = m_tap;
    exp_sw  = m_pending;
    m_edge     = m_btn_line[1] && !m_btn_line[2];
    m_btn_line = {m_btn_line[1:0], step_btn};
    m_sw_line  = {m_sw_line[0], sw_slow};
    m_st_line  = {m_st_line[0], step_mode};
    m_prev_div = clkdiv;
    m_prev_ok  = 1'b1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    clkdiv = clkdiv + 32'd1;
    ncyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) cyc();
    checks++;
    if ({cpu_en, tap_sel, switching, en_count} !== 7'd0) begin
      errors++;
      $display("FAIL reset_values got en/tap/sw/cnt=%b/%b/%b/%0d want 0/0/0/0", cpu_en, tap_sel, switching, en_count);
    end
    clkdiv = 32'd0;
    rst = 1'b0;
  endtask

  task automatic test_fast_run();
    int first, last, nstr, gap_bad, i;
    first = -1; last = -1; nstr = 0; gap_bad = 0; i = 0;
    while (nstr < 5 && i < 40) begin
      cyc(); i++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL fast_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
      if (cpu_en) begin
        if (first < 0) first = int'(clkdiv);
        else if (int'(clkdiv) - last != 4) gap_bad++;
        last = int'(clkdiv);
        nstr++;
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL first_strobe got clkdiv=%0d want 3", first);
    end
    checks++;
    if (nstr != 5 || gap_bad != 0) begin
      errors++;
      $display("FAIL fast_period got strobes=%0d bad_gaps=%0d want 5/0", nstr, gap_bad);
    end
    checks++;
    if (en_count !== 4'd5) begin
      errors++;
      $display("FAIL en_count5 got %0d want 5", en_count);
    end
  endtask

  task automatic test_slow_switch();
    int lat, v, gap;
    sw_slow = 1'b1;
    lat = 0;
    while (!switching && lat < 10) begin
      cyc(); lat++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL slow_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL switch_latency got %0d want 3", lat);
    end
    v = -1; gap = 0;
    while (v < 0 && gap < 80) begin
      cyc(); gap++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL slow_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
      if (cpu_en) v = int'(clkdiv);
    end
    checks++;
    if (v < 0 || ((v - 1) % 32) != 16 || tap_sel !== 1'b1) begin
      errors++;
      $display("FAIL slow_first got clkdiv=%0d tap=%b want (clkdiv-1)%%32=16 tap=1", v, tap_sel);
    end
    gap = 0;
    do begin
      cyc(); gap++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL slow_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end while (!cpu_en && gap < 80);
    checks++;
    if (gap != 32) begin
      errors++;
      $display("FAIL slow_period got %0d want 32", gap);
    end
  endtask

  task automatic test_step();
    int n, lat, got, extra;
    step_mode = 1'b1;
    n = 0;
    repeat (4) begin
      cyc();
      if (cpu_en) n++;
    end
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1;
      got = 0; lat = 0;
      for (int j = 0; j < 8; j++) begin
        cyc(); lat++;
        checks++;
        if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
          errors++;
          $display("FAIL step_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
        end
        if (cpu_en) begin
          n++;
          if (got == 0) got = lat;
        end
        if (j == 1) step_btn = 1'b0;
      end
      checks++;
      if (got != 4) begin
        errors++;
        $display("FAIL step_latency pulse=%0d got %0d want 4", p, got);
      end
      extra = $urandom_range(0, 5);
      repeat (extra) begin
        cyc();
        if (cpu_en) n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL step_count got %0d want 3", n);
    end
    step_mode = 1'b0;
    sw_slow = 1'b0;
    repeat (12) begin
      cyc();
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL step_exit cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end
  endtask

  task automatic test_halt();
    logic [CNT_W-1:0] c0;
    int n, i;
    i = 0;
    do begin
      cyc(); i++;
    end while (!cpu_en && i < 12);
    halt = 1'b1;
    c0 = en_count;
    n = 0;
    repeat (8) begin
      cyc();
      if (cpu_en) n++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL halt_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end
    checks++;
    if (n != 0 || en_count !== c0) begin
      errors++;
      $display("FAIL halt_block got strobes=%0d cnt=%0d want 0/%0d", n, en_count, c0);
    end
    halt = 1'b0;
    i = 0;
    do begin
      cyc(); i++;
    end while (!cpu_en && i < 5);
    checks++;
    if (cpu_en !== 1'b1 || en_count !== c0 + 4'd1) begin
      errors++;
      $display("FAIL halt_release got en=%b cnt=%0d after %0d cycles want 1/%0d", cpu_en, en_count, i, c0 + 4'd1);
    end
  endtask

  task automatic test_toggle();
    int i, v;
    i = 0;
    while ((clkdiv % 32) != 17 && i < 40) begin
      cyc(); i++;
    end
    sw_slow = 1'b1;
    i = 0;
    while (!switching && i < 6) begin
      cyc(); i++;
    end
    cyc();
    sw_slow = 1'b0;
    v = -1; i = 0;
    while (v < 0 && i < 40) begin
      cyc(); i++;
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL toggle_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
      if (cpu_en) v = int'(clkdiv);
    end
    checks++;
    if (v < 0 || tap_sel !== 1'b0 || ((v - 1) % 4) != 2) begin
      errors++;
      $display("FAIL toggle_align got clkdiv=%0d tap=%b want (clkdiv-1)%%4=2 tap=0", v, tap_sel);
    end
  endtask

  task automatic test_random();
    logic prev_en;
    int consec;
    prev_en = 1'b0; consec = 0;
    for (int k = 0; k < 600; k++) begin
      halt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 59) == 0) sw_slow = ~sw_slow;
      if ($urandom_range(0, 119) == 0) step_mode = ~step_mode;
      cyc();
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL rand_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
      if (cpu_en && prev_en) consec++;
      prev_en = cpu_en;
    end
    checks++;
    if (consec != 0) begin
      errors++;
      $display("FAIL strobe_spacing got %0d back-to-back strobes want 0", consec);
    end
  endtask

  task automatic test_rst_mid();
    int i;
    halt = 1'b0; step_btn = 1'b0; sw_slow = 1'b0; step_mode = 1'b0;
    repeat (40) begin
      cyc();
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL settle_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end
    i = 0;
    while ((clkdiv % 4) != 2 && i < 8) begin
      cyc(); i++;
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({cpu_en, tap_sel, switching, en_count} !== 7'd0) begin
      errors++;
      $display("FAIL rst_async got en/tap/sw/cnt=%b/%b/%b/%0d want 0/0/0/0", cpu_en, tap_sel, switching, en_count);
    end
    cyc();
    checks++;
    if ({cpu_en, tap_sel, switching, en_count} !== 7'd0) begin
      errors++;
      $display("FAIL rst_strobe got en/tap/sw/cnt=%b/%b/%b/%0d want 0/0/0/0", cpu_en, tap_sel, switching, en_count);
    end
    rst = 1'b0;
    repeat (12) begin
      cyc();
      checks++;
      if ({cpu_en, tap_sel, switching, en_count} !== {exp_en, exp_tap, exp_sw, exp_cnt}) begin
        errors++;
        $display("FAIL post_rst_model cyc=%0d got en/tap/sw/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", ncyc, cpu_en, tap_sel, switching, en_count, exp_en, exp_tap, exp_sw, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_run();
    test_slow_switch();
    test_step();
    test_halt();
    test_toggle();
    test_random();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
